// File: rtl/ntt_fwd.sv
// ntt_fwd -- streaming negacyclic forward NTT over Z_q.
//
// Coefficients a[0..N-1] stream in on poly_in. Each one is reduced mod q,
// pre-scaled by phi[n] = PSI^n and written to a register file at address
// bitrev(n). An in-place radix-2 Cooley-Tukey pass of logN stages then runs
// one butterfly per cycle. The result X[0..N-1] streams out in natural order.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   poly_in carries a coefficient
//   poly_in   in   [logq-1:0] input coefficient, natural order
//   in_ready  out  block accepts a coefficient this cycle (STORE)
//   out_valid out  poly_out carries a result (OUTPUT)
//   poly_out  out  [logq-1:0] result coefficient, natural order
//   out_ready in   downstream consumes poly_out this cycle
module ntt_fwd #(
  parameter int q    = 17,
  parameter int N    = 8,
  parameter int logq = 5,
  parameter int logN = 3,
  parameter int PSI  = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [logq-1:0] poly_in,
  output logic            in_ready,
  output logic            out_valid,
  output logic [logq-1:0] poly_out,
  input  logic            out_ready
);

  localparam int OMEGA = (PSI * PSI) % q;
  localparam int SW    = (logN > 1) ? $clog2(logN) : 1;

  localparam logic [1:0] ST_STORE   = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  localparam logic [logq-1:0]   Q_L = logq'(q);
  localparam logic [logq:0]     Q_1 = (logq + 1)'(q);
  localparam logic [2*logq-1:0] Q_W = (2 * logq)'(q);

  // Twiddle tables base^0 .. base^(N-1) mod q, built at elaboration.
  typedef logic [N-1:0][logq-1:0] rom_t;

  function automatic rom_t gen_rom(input int base);
    rom_t   r;
    longint acc;
    acc = 1;
    for (int k = 0; k < N; k++) begin
      r[k] = logq'(acc);
      acc  = (acc * base) % q;
    end
    return r;
  endfunction

  localparam rom_t PHI = gen_rom(PSI);
  localparam rom_t W   = gen_rom(OMEGA);

  // Full-width product, then a single reduction.
  function automatic logic [logq-1:0] mul_mod(input logic [logq-1:0] a,
                                              input logic [logq-1:0] b);
    logic [2*logq-1:0] p;
    p = (2 * logq)'(a) * (2 * logq)'(b);
    return logq'(p % Q_W);
  endfunction

  // Operands are already < q, so one conditional correction suffices.
  function automatic logic [logq-1:0] add_mod(input logic [logq-1:0] a,
                                              input logic [logq-1:0] b);
    logic [logq:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_1) s = s - Q_1;
    return s[logq-1:0];
  endfunction

  function automatic logic [logq-1:0] sub_mod(input logic [logq-1:0] a,
                                              input logic [logq-1:0] b);
    logic [logq:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + Q_1 - {1'b0, b};
    return s[logq-1:0];
  endfunction

  function automatic logic [logN-1:0] bitrev(input logic [logN-1:0] v);
    logic [logN-1:0] r;
    for (int k = 0; k < logN; k++) r[k] = v[logN-1-k];
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [logN-1:0] cnt_q, cnt_d;     // input index, butterfly index, output index
  logic [SW-1:0]   stg_q, stg_d;
  logic [logq-1:0] c_q [N];

  logic [logN-1:0] h_v, p_v, bf_i, bf_j, tw_idx;
  logic [logq-1:0] in_coef, t_v, sum_v, diff_v;
  logic            last_bf;

  assign in_ready  = (state_q == ST_STORE);
  assign out_valid = (state_q == ST_OUTPUT);
  assign poly_out  = out_valid ? c_q[cnt_q] : '0;

  // Butterfly addressing: h = 2^s, p = b mod h, i = (b>>s)*2h + p, j = i + h,
  // twiddle index p*N/(2h) = p << (logN-1-s).
  assign h_v     = logN'(1) << stg_q;
  assign p_v     = cnt_q & (h_v - 1'b1);
  assign bf_i    = ((cnt_q >> stg_q) << (int'(stg_q) + 1)) | p_v;
  assign bf_j    = bf_i | h_v;
  assign tw_idx  = p_v << (SW'(logN - 1) - stg_q);
  assign t_v     = mul_mod(c_q[bf_j], W[tw_idx]);
  assign sum_v   = add_mod(c_q[bf_i], t_v);
  assign diff_v  = sub_mod(c_q[bf_i], t_v);
  assign in_coef = mul_mod(poly_in % Q_L, PHI[cnt_q]);
  assign last_bf = (stg_q == SW'(logN - 1)) && (cnt_q == logN'(N / 2 - 1));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    case (state_q)
      ST_STORE: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == logN'(N - 1)) begin
            cnt_d   = '0;
            stg_d   = '0;
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        if (last_bf) begin
          cnt_d   = '0;
          stg_d   = '0;
          state_d = ST_OUTPUT;
        end else if (cnt_q == logN'(N / 2 - 1)) begin
          cnt_d = '0;
          stg_d = stg_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == logN'(N - 1)) begin
            cnt_d   = '0;
            state_d = ST_STORE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        stg_d   = '0;
        state_d = ST_STORE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STORE;
      cnt_q   <= '0;
      stg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
    end
  end

  // NOTE: the coefficient file has no reset; every entry is rewritten in
  // STORE before it is read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (state_q == ST_STORE && in_valid) begin
      c_q[bitrev(cnt_q)] <= in_coef;
    end else if (state_q == ST_COMPUTE) begin
      c_q[bf_i] <= sum_v;
      c_q[bf_j] <= diff_v;
    end
  end

endmodule

// File: tb/tb_ntt_fwd.sv
// tb_ntt_fwd -- self-checking bench for ntt_fwd.
// Expected spectra come from the direct negacyclic NTT sum; random frames are
// also pushed back through the inverse transform to recover the input.
module tb_ntt_fwd;

  localparam int Q    = 17;
  localparam int N    = 8;
  localparam int LOGQ = 5;
  localparam int LOGN = 3;
  localparam int PSI  = 3;
  localparam int OMEGA = (PSI * PSI) % Q;
  localparam int LAT  = LOGN * N / 2 + 1;

  typedef int vec_t [N];

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [LOGQ-1:0] poly_in = '0;
  logic            in_ready;
  logic            out_valid;
  logic [LOGQ-1:0] poly_out;
  logic            out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  ntt_fwd #(.q(Q), .N(N), .logq(LOGQ), .logN(LOGN), .PSI(PSI)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .poly_in   (poly_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .poly_out  (poly_out),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pw(input int b, input int e);
    longint r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % Q;
    return int'(r);
  endfunction

  function automatic vec_t golden(input vec_t a);
    vec_t x;
    longint acc;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int j = 0; j < N; j++)
        acc = (acc + longint'(a[j] % Q) * pw(PSI, j) % Q * pw(OMEGA, j * k)) % Q;
      x[k] = int'(acc);
    end
    return x;
  endfunction

  function automatic vec_t inverse(input vec_t x);
    vec_t a;
    longint acc;
    int ninv, oinv, pinv;
    ninv = pw(N, Q - 2);
    oinv = pw(OMEGA, Q - 2);
    pinv = pw(PSI, Q - 2);
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int k = 0; k < N; k++)
        acc = (acc + longint'(x[k]) * pw(oinv, j * k)) % Q;
      a[j] = int'((acc * ninv % Q) * pw(pinv, j) % Q);
    end
    return a;
  endfunction

  // ready_mode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic run_frame(input string name, input vec_t a, input vec_t exp,
                           input bit gaps, input int ready_mode, input bit noise,
                           input bit inv_chk);
    vec_t got;
    int n = 0, m = 0, cyc = 0, acc_cyc = -1, first_ov = -1;
    bit holding = 0;
    logic [LOGQ-1:0] held = '0;
    while (m < N && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (n < N) begin
        check({name, " in_ready_store"}, in_ready, 1);
        in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        poly_in   = LOGQ'(a[n]);
        out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (in_valid) begin
          n++;
          if (n == N) acc_cyc = cyc;
        end
      end else begin
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        poly_in  = LOGQ'($urandom);
        check({name, " in_ready_busy"}, in_ready, 0);
        if (out_valid || first_ov >= 0) begin
          check({name, " out_valid"}, out_valid, 1);
          if (first_ov < 0) begin
            first_ov = cyc;
            check({name, " latency"}, cyc - acc_cyc, LAT);
          end
          if (holding) check({name, " hold"}, poly_out, held);
          case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc - first_ov) % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
          endcase
          if (out_ready) begin
            check($sformatf("%s X[%0d]", name, m), poly_out, exp[m]);
            got[m]  = int'(poly_out);
            m++;
            holding = 0;
          end else begin
            holding = 1;
            held    = poly_out;
          end
        end else begin
          out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
    if (m < N) check({name, " timeout"}, m, N);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({name, " in_ready_return"}, in_ready, 1);
    check({name, " out_valid_return"}, out_valid, 0);
    if (inv_chk && m == N) begin
      vec_t back;
      back = inverse(got);
      for (int j = 0; j < N; j++)
        check($sformatf("%s inv a[%0d]", name, j), back[j], a[j] % Q);
    end
  endtask

  initial begin
    vec_t imp, imp2, shf, ones, twos, shf_x, rnd;
    imp   = '{1, 0, 0, 0, 0, 0, 0, 0};
    imp2  = '{2, 0, 0, 0, 0, 0, 0, 0};
    shf   = '{0, 1, 0, 0, 0, 0, 0, 0};
    ones  = '{1, 1, 1, 1, 1, 1, 1, 1};
    twos  = '{2, 2, 2, 2, 2, 2, 2, 2};
    shf_x = '{3, 10, 5, 11, 14, 7, 12, 6};

    // Reset state.
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_frame("impulse", imp, ones, 0, 0, 0, 0);
    run_frame("shifted", shf, shf_x, 0, 0, 0, 0);
    run_frame("backpressure", imp2, twos, 0, 1, 0, 0);
    run_frame("gaps", shf, shf_x, 1, 0, 1, 0);

    // Reset in the middle of COMPUTE.
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      poly_in  = LOGQ'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame("after_reset", imp, ones, 0, 0, 0, 0);

    // Reset in the middle of STORE: the partial frame is discarded.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      poly_in  = LOGQ'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("storereset in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame("after_store_reset", shf, shf_x, 0, 0, 0, 0);

    // Random frames, including unreduced inputs >= q.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) rnd[k] = int'($urandom_range(0, (1 << LOGQ) - 1));
      run_frame($sformatf("rand%0d", f), rnd, golden(rnd), f[0], 2, 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
